int_ctrl: RTL

Interrupt controller that drives the `Ireq`/`Iack` interrupt handshake into the multi-cycle CPU (`Muliti_cycle_Cpu`). It latches rising edges on 8 peripheral interrupt lines, applies a software mask and fixed priority, and raises `Ireq` until the CPU acknowledges. It then holds the acknowledged source in service until the CPU writes end-of-interrupt (EOI) over the memory-mapped I/O (MIO) bus. It sits on the MIO bus beside the other peripherals; the CPU reads the in-service id to dispatch.

---
 rtl/int_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending, mask, fixed lowest-index priority,
// Ireq/Iack handshake to the CPU, in-service hold until an EOI write on the MIO bus.
module int_ctrl #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   output logic             Ireq,
   input  logic             Iack,
   input  logic             sel,
   input  logic             mem_w,
   input  logic [3:0]       addr,
   input  logic [31:0]      data_in,
   output logic [31:0]      data_out
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   localparam logic [1:0] A_PEND = 2'd0;
   localparam logic [1:0] A_MASK = 2'd1;
   localparam logic [1:0] A_VEC  = 2'd2;
   localparam logic [1:0] A_EOI  = 2'd3;

   state_t           state_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] prev_q;
   logic             svc_valid_q;
   logic [2:0]       svc_id_q;
   logic             ireq_q;

   logic [N_SRC-1:0] active, rise, clr, win_oh;
   logic [2:0]       win_id;
   logic             wr, take_ack, eoi_wr;

   assign wr       = sel && mem_w;
   assign active   = pend_q & mask_q;
   assign rise     = irq_in & ~prev_q;
   assign take_ack = (state_q == REQ) && Iack && (|active);
   assign eoi_wr   = wr && (addr[3:2] == A_EOI);

   // Descending scan so the lowest active index is the last one written.
   always_comb begin
      win_id = 3'd0;
      win_oh = '0;
      for (int i = N_SRC-1; i >= 0; i--) begin
         if (active[i]) begin
            win_id = 3'(i);
            win_oh = N_SRC'(1) << i;
         end
      end
   end

   // Clears are applied before new edges so a coincident rising edge wins.
   always_comb begin
      clr = '0;
      if (wr && (addr[3:2] == A_PEND)) clr = clr | data_in[N_SRC-1:0];
      if (take_ack)                    clr = clr | win_oh;
      pend_d = (pend_q & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         mask_q      <= '0;
         prev_q      <= '0;
         svc_valid_q <= 1'b0;
         svc_id_q    <= 3'd0;
         ireq_q      <= 1'b0;
      end else begin
         prev_q <= irq_in;
         pend_q <= pend_d;
         if (wr && (addr[3:2] == A_MASK)) mask_q <= data_in[N_SRC-1:0];
         case (state_q)
            IDLE: begin
               if (|active) begin
                  state_q <= REQ;
                  ireq_q  <= 1'b1;
               end
            end
            REQ: begin
               if (take_ack) begin
                  state_q     <= SERVICE;
                  ireq_q      <= 1'b0;
                  svc_id_q    <= win_id;
                  svc_valid_q <= 1'b1;
               end else if (!(|active)) begin
                  state_q <= IDLE;
                  ireq_q  <= 1'b0;
               end
            end
            SERVICE: begin
               if (eoi_wr) begin
                  state_q     <= IDLE;
                  svc_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ireq_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Ireq = ireq_q;

   always_comb begin
      data_out = 32'd0;
      if (sel) begin
         case (addr[3:2])
            A_PEND:  data_out = {{(32-N_SRC){1'b0}}, pend_q};
            A_MASK:  data_out = {{(32-N_SRC){1'b0}}, mask_q};
            A_VEC:   data_out = {23'd0, svc_valid_q, 5'd0, svc_id_q};
            default: data_out = 32'd0;
         endcase
      end
   end

endmodule
